// File: rtl/bist_pkg.sv
// Shared types and constants for the March C- BIST sequencer.
package bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  localparam int NUM_ELEM = 6;

  localparam logic [1:0] MODE_SOLID  = 2'b00;
  localparam logic [1:0] MODE_CHECK  = 2'b01;
  localparam logic [1:0] MODE_NIBBLE = 2'b10;

  localparam logic [7:0] BG_SOLID  = 8'h00;
  localparam logic [7:0] BG_CHECK  = 8'h55;
  localparam logic [7:0] BG_NIBBLE = 8'h0F;

  // One march operation: read or write, data polarity, address direction,
  // and whether it is the final op at the current address.
  typedef struct packed {
    logic rd;
    logic pol;
    logic desc;
    logic last;
  } march_op_t;

  // E3 and E4 walk the address space downwards.
  function automatic logic elem_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // First background byte for a mode; mode 11 falls back to solid.
  function automatic logic [7:0] bg_byte(input logic [1:0] m);
    case (m)
      MODE_CHECK:  return BG_CHECK;
      MODE_NIBBLE: return BG_NIBBLE;
      default:     return BG_SOLID;
    endcase
  endfunction

endpackage

// File: rtl/bist_march_rom.sv
// March C- element table: maps (elem, phase) to the op to issue.
module bist_march_rom
  import bist_pkg::*;
(
  input  logic [2:0] elem,
  input  logic       phase,
  output march_op_t  op
);

  // E0 w0 | E1 r0,w1 | E2 r1,w0 | E3 r0,w1 | E4 r1,w0 | E5 r0
  always_comb begin
    op      = '0;
    op.desc = elem_desc(elem);
    case (elem)
      3'd0: begin
        op.rd   = 1'b0;
        op.pol  = 1'b0;
        op.last = 1'b1;
      end
      3'd1, 3'd3: begin
        op.rd   = !phase;
        op.pol  = phase;
        op.last = phase;
      end
      3'd2, 3'd4: begin
        op.rd   = !phase;
        op.pol  = !phase;
        op.last = phase;
      end
      3'd5: begin
        op.rd   = 1'b1;
        op.pol  = 1'b0;
        op.last = 1'b1;
      end
      default: op.last = 1'b1;
    endcase
  end

endmodule

// File: rtl/bist_march_ctrl.sv
// March C- BIST sequencer for a 2^ADDR_WIDTH-entry SRAM.
// Optional first-failure capture is built when BIST_FAIL_LOG_EN is defined.
module bist_march_ctrl
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

  state_t                state;
  logic [2:0]            elem;
  logic                  phase;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            mode_q;
  march_op_t             op;
  logic [7:0]            bg_b;
  logic [DATA_WIDTH-1:0] bg, pat;
  logic                  run_st, issue, at_end, start_acc, miss;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_exp;

  bist_march_rom u_rom (.elem(elem), .phase(phase), .op(op));

  // Background word: the mode's byte pattern repeated across the data width.
  always_comb begin
    bg_b = bg_byte(mode_q);
    bg   = '0;
    for (int i = 0; i < DATA_WIDTH; i++) bg[i] = bg_b[i % 8];
  end

  assign pat       = op.pol ? ~bg : bg;
  assign run_st    = (state == RUN);
  assign issue     = run_st && mem_gnt;
  assign at_end    = (addr == (op.desc ? ADDR_ZERO : ADDR_LAST));
  assign start_acc = (state == IDLE) && start;

  // Strobes are qualified by the grant in the same cycle so a lost grant
  // never leaks an op onto the port; address/data come from registers.
  assign mem_we    = issue && !op.rd;
  assign mem_re    = issue && op.rd;
  assign mem_wdata = run_st ? pat : '0;
  assign mem_addr  = addr;

  // Sequencing FSM: walks elements/addresses, only advancing on grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      elem    <= '0;
      phase   <= 1'b0;
      addr    <= '0;
      mode_q  <= '0;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          elem    <= '0;
          phase   <= 1'b0;
          addr    <= '0;
          mode_q  <= mode;
          mem_req <= 1'b1;
          busy    <= 1'b1;
        end
        RUN: if (mem_gnt) begin
          if (!op.last) begin
            phase <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (!at_end)
              addr <= op.desc ? addr - 1'b1 : addr + 1'b1;
            else if (elem == 3'(NUM_ELEM - 1))
              state <= FLUSH;
            else begin
              elem <= elem + 3'd1;
              addr <= elem_desc(elem + 3'd1) ? ADDR_LAST : ADDR_ZERO;
            end
          end
        end
        FLUSH: begin
          state   <= DONE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: if (!start) begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miss = rd_vld && (mem_rdata != rd_exp);

  // Read-compare pipeline: expected data travels one cycle behind the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= 1'b0;
      rd_exp <= '0;
      fail   <= 1'b0;
    end else begin
      rd_vld <= mem_re;
      rd_exp <= pat;
      if (start_acc)
        fail <= 1'b0;
      else if (miss)
        fail <= 1'b1;
    end
  end

`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            rd_elem;

  // First-failure capture; fail still low means this is the first miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_elem   <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      if (mem_re) begin
        rd_addr <= addr;
        rd_elem <= elem;
      end
      if (start_acc) begin
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (miss && !fail) begin
        fail_addr <= rd_addr;
        fail_elem <= rd_elem;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
`endif

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Self-checking bench for bist_march_ctrl: SRAM model with fault injection,
// algorithmic March C- reference, grant-loss and reset scenarios.
module tb_bist_march_ctrl;
  localparam int AW = 4, DW = 8, DEPTH = 1 << AW, NOPS = 10 * DEPTH;

  logic clk = 0, rst = 1, start = 0, mem_gnt = 1;
  logic [1:0] mode = 0;
  logic [DW-1:0] mem_rdata = 0;
  logic mem_req, mem_we, mem_re, busy, done, fail;
  logic [AW-1:0] mem_addr, fail_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0] fail_elem;

  always #5 clk = ~clk;

  bist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .fail(fail), .fail_addr(fail_addr), .fail_elem(fail_elem));

  typedef struct packed {logic we; logic re; logic [AW-1:0] addr; logic [DW-1:0] data;} op_t;
  op_t obs_q[$], exp_q[$];

  int total = 0, bad = 0;
  int edge_cnt = 0;
  bit arm = 0;
  int gnt_kind = 0, lo_from = 0, lo_len = 0;
  int flt_kind = 0, flt_a = 0, flt_b = 0;
  bit flt_val = 0;
  logic [DW-1:0] mem [DEPTH];
  int grants = 0, exp_done_edge = -1, fail_edge = -1;
  int strb_total = 0, strb_gnt_lo = 0, strb_idle = 0;

  // Edge index relative to the start-sampling edge (which is edge 1).
  always @(posedge clk) edge_cnt <= arm ? 1 : edge_cnt + 1;

  // Grant driver, changed well away from the active edge.
  always @(posedge clk) begin
    #2;
    case (gnt_kind)
      1:       mem_gnt = !(edge_cnt >= lo_from && edge_cnt < lo_from + lo_len);
      2:       mem_gnt = ($urandom_range(3) != 0);
      default: mem_gnt = 1'b1;
    endcase
  end

  function automatic logic [DW-1:0] rd_fault(input int a, input logic [DW-1:0] v);
    logic [DW-1:0] m;
    m = DW'(1) << flt_b;
    if (flt_kind == 1 && a == flt_a) return flt_val ? (v | m) : (v & ~m);
    return v;
  endfunction

  // SRAM model: one-cycle read latency, stuck-at on read, coupling on write.
  always @(posedge clk) begin
    if (arm) for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    if (mem_re) mem_rdata <= rd_fault(int'(mem_addr), mem[mem_addr]);
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      if (flt_kind == 2 && int'(mem_addr) == flt_a) mem[flt_b] = ~mem[flt_b];
    end
  end

  // Port monitor: op log, strobe legality, granted-cycle latency model.
  always @(negedge clk) begin
    op_t o;
    if (edge_cnt == 1) begin obs_q.delete(); grants = 0; fail_edge = -1; end
    if (mem_we || mem_re) begin
      o.we = mem_we; o.re = mem_re; o.addr = mem_addr; o.data = mem_we ? mem_wdata : '0;
      obs_q.push_back(o);
      strb_total++;
      if (!mem_gnt) strb_gnt_lo++;
      if (!busy) strb_idle++;
    end
    if (edge_cnt >= 1 && grants < NOPS && mem_gnt) begin
      grants++;
      if (grants == NOPS) exp_done_edge = edge_cnt + 2;
    end
    if (fail && fail_edge < 0) fail_edge = edge_cnt;
  end

  function automatic logic [DW-1:0] bgv(input logic [1:0] md);
    case (md)
      2'b01:   return 8'h55;
      2'b10:   return 8'h0F;
      default: return 8'h00;
    endcase
  endfunction

  // Reference March C- op list and fault-aware outcome, from the algorithm.
  task automatic model(input logic [1:0] md, output bit f, output int fa, output int fe, output int fidx);
    logic [DW-1:0] m [DEPTH];
    logic [DW-1:0] bg, rv, ev;
    op_t o;
    int idx, a;
    bit rp;
    bg = bgv(md); f = 0; fa = 0; fe = 0; fidx = -1; idx = 0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < DEPTH; i++) begin
        a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
        rp = (e == 2 || e == 4);
        if (e != 0) begin
          o.we = 0; o.re = 1; o.addr = AW'(a); o.data = '0; exp_q.push_back(o);
          rv = rd_fault(a, m[a]); ev = rp ? ~bg : bg;
          if (!f && rv != ev) begin f = 1; fa = a; fe = e; fidx = idx; end
          idx++;
        end
        if (e != 5) begin
          o.we = 1; o.re = 0; o.addr = AW'(a);
          o.data = (e == 0) ? bg : (rp ? bg : ~bg);
          exp_q.push_back(o);
          m[a] = o.data;
          if (flt_kind == 2 && a == flt_a) m[flt_b] = ~m[flt_b];
          idx++;
        end
      end
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, o, e);
    end
  endtask

  task automatic run_test(input string tag, input logic [1:0] md, input int fk, input int fa, input int fb,
                          input bit fv, input int gk, input int lf, input int ll, input bit hold,
                          input int want_edge);
    bit ef; int efa, efe, efi, de, nerr, s_lo, s_idle; bit held;
    flt_kind = fk; flt_a = fa; flt_b = fb; flt_val = fv;
    model(md, ef, efa, efe, efi);
    s_lo = strb_gnt_lo; s_idle = strb_idle;
    @(negedge clk);
    mode = md; start = 1; arm = 1;
    gnt_kind = gk; lo_from = lf; lo_len = ll;
    @(posedge clk); #1; arm = 0;
    chk({tag, "_busy1"}, {30'd0, busy, mem_req}, 32'd3);
    chk({tag, "_fail_clr"}, {31'd0, fail}, 32'd0);
    de = -1;
    for (int k = 0; k < 600 && de < 0; k++) begin
      @(posedge clk); #1;
      if (done) de = edge_cnt;
    end
    chk({tag, "_done_edge"}, de, exp_done_edge);
    if (want_edge >= 0) chk({tag, "_done_abs"}, de, want_edge);
    chk({tag, "_fail"}, {31'd0, fail}, {31'd0, ef});
`ifdef BIST_FAIL_LOG_EN
    chk({tag, "_faddr"}, fail_addr, efa);
    chk({tag, "_felem"}, fail_elem, efe);
`else
    chk({tag, "_faddr"}, fail_addr, 0);
    chk({tag, "_felem"}, fail_elem, 0);
`endif
    if (gk == 0 && ef) chk({tag, "_fail_edge"}, fail_edge, efi + 3);
    chk({tag, "_nops"}, obs_q.size(), exp_q.size());
    nerr = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) nerr++;
    chk({tag, "_seq"}, nerr, 0);
    chk({tag, "_no_strb_gnt_lo"}, strb_gnt_lo - s_lo, 0);
    chk({tag, "_no_strb_idle"}, strb_idle - s_idle, 0);
    if (hold) begin
      held = 1;
      repeat (6) begin @(posedge clk); #1; if (!done || busy) held = 0; end
      chk({tag, "_hold_done"}, {31'd0, held}, 32'd1);
    end
    start = 0;
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    int n0, s0, md, fk, fa, fb;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {mem_req, mem_we, mem_re, busy, done, fail, mem_addr, mem_wdata, fail_addr, fail_elem},
        32'd0);
    @(negedge clk); rst = 0;

    // Clean solid run, full grant.
    run_test("clean", 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 162);
    n0 = 0;
    for (int i = 0; i < DEPTH && i < obs_q.size(); i++)
      if (obs_q[i].we && obs_q[i].data == 8'h00 && int'(obs_q[i].addr) == i) n0++;
    chk("e0_writes", n0, DEPTH);
    if (obs_q.size() > 0) chk("last_op", {obs_q[obs_q.size()-1].re, obs_q[obs_q.size()-1].addr}, {1'b1, 4'd15});
    else chk("last_op", 0, 1);

    // Stuck-at-1 on bit 0 at address 5, checkerboard.
    run_test("stuck", 2'b01, 1, 5, 0, 1, 0, 0, 0, 0, -1);

    // Grant drop for 7 cycles inside E3 (E3 starts at cycle 81).
    run_test("gntlo", 2'b10, 0, 0, 0, 0, 1, 90, 7, 0, 169);

    // Reset pulse 50 cycles into a run.
    @(negedge clk); mode = 2'b00; start = 1; arm = 1; gnt_kind = 0; flt_kind = 0;
    @(posedge clk); #1; arm = 0;
    while (edge_cnt < 50) begin @(posedge clk); #1; end
    rst = 1; start = 0;
    @(posedge clk); #1;
    chk("rst_mid", {mem_req, mem_we, mem_re, busy, done, fail, mem_addr, mem_wdata, fail_addr, fail_elem},
        32'd0);
    rst = 0; s0 = strb_total;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_quiet", {strb_total - s0, 30'd0, busy, done}, 32'd0);
    run_test("after_rst", 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 162);

    // Coupling fault (write to 3 flips 4), start held through DONE.
    run_test("couple", 2'b10, 2, 3, 4, 0, 0, 0, 0, 1, -1);
    // New run must clear the sticky fail from the previous one.
    run_test("reclean", 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 162);

    // Randomised modes, faults and grant patterns.
    for (int r = 0; r < 3; r++) begin
      md = $urandom_range(3); fk = $urandom_range(2); fa = $urandom_range(DEPTH - 1);
      fb = (fk == 2) ? (fa + 1 + $urandom_range(DEPTH - 2)) % DEPTH : $urandom_range(DW - 1);
      run_test($sformatf("rand%0d", r), 2'(md), fk, fa, fb, 1'($urandom_range(1)), 2, 0, 0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
